// File: rtl/led_blink_bank.sv
// led_blink_bank: bank of N_CH independent LED blinkers with OFF/ON/BLINK/BURST modes.
// Latency: config writes and sync take effect on the sampling edge; led/tick are registered.
// Backpressure: none; cfg_we and sync are accepted unconditionally every cycle.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        asynchronous active-high reset
//   cfg_we     config write strobe; cfg_ch selects the channel (out-of-range is ignored)
//   cfg_mode   0=OFF 1=ON 2=BLINK 3=BURST
//   cfg_half   half-period in clk cycles (0 behaves as 1)
//   cfg_burst  pulses per burst (0 makes BURST behave as OFF)
//   sync       restarts every channel from phase 0, config kept
//   led        registered LED drive, bit i = channel i
//   tick       one-cycle pulse whenever led[i] toggles due to counting
module led_blink_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int DEF_HALF   = 25000000,
  parameter int GAP_HALVES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [3:0]       cfg_burst,
  input  logic             sync,
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  tick
);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_BURST = 2'd3
  } mode_t;

  // Burst channels alternate between emitting pulses and a dark gap.
  typedef enum logic {
    PH_ACTIVE = 1'b0,
    PH_GAP    = 1'b1
  } phase_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [3:0]       burst_q, burst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       tcnt_q, tcnt_d;
    phase_t           ph_q, ph_d;
    logic             led_q, led_d;
    logic             tick_q, tick_d;

    logic             wr;
    logic [CNT_W-1:0] eff_half;
    logic             wrap;
    logic [4:0]       tcnt_inc;

    // Equality against the channel index implies cfg_ch < N_CH, so
    // out-of-range writes never match any channel.
    assign wr       = cfg_we && (cfg_ch == 4'(i));
    assign eff_half = (half_q == '0) ? CNT_W'(1) : half_q;
    // Counter only ever runs 0..eff_half-1, so it cannot wrap through 2^CNT_W.
    assign wrap     = (cnt_q == eff_half - CNT_W'(1));
    assign tcnt_inc = tcnt_q + 5'd1;

    always_comb begin
      mode_d  = mode_q;
      half_d  = half_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      ph_d    = ph_q;
      led_d   = led_q;
      tick_d  = 1'b0;

      if (wr || sync) begin
        // Restart from phase 0; a write also swaps in the new config so a
        // simultaneous sync aligns the written channel with the others.
        if (wr) begin
          mode_d  = mode_t'(cfg_mode);
          half_d  = cfg_half;
          burst_d = cfg_burst;
        end
        cnt_d  = '0;
        tcnt_d = '0;
        ph_d   = PH_ACTIVE;
        led_d  = (mode_d == M_ON);
      end else begin
        case (mode_q)
          M_OFF: begin
            led_d = 1'b0;
            cnt_d = '0;
          end
          M_ON: begin
            led_d = 1'b1;
            cnt_d = '0;
          end
          M_BLINK: begin
            if (wrap) begin
              cnt_d  = '0;
              led_d  = ~led_q;
              tick_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          M_BURST: begin
            if (burst_q == 4'd0) begin
              led_d = 1'b0;
              cnt_d = '0;
            end else if (ph_q == PH_GAP) begin
              // In the gap the toggle counter is reused to count dark
              // half-periods; leaving the gap is silent (no tick).
              led_d = 1'b0;
              if (wrap) begin
                cnt_d = '0;
                if (tcnt_inc == 5'(GAP_HALVES)) begin
                  ph_d   = PH_ACTIVE;
                  tcnt_d = '0;
                end else begin
                  tcnt_d = tcnt_inc;
                end
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              if (wrap) begin
                cnt_d  = '0;
                led_d  = ~led_q;
                tick_d = 1'b1;
                // 2*burst toggles bring the LED back low: burst complete.
                if (tcnt_inc == {burst_q, 1'b0}) begin
                  ph_d   = PH_GAP;
                  tcnt_d = '0;
                end else begin
                  tcnt_d = tcnt_inc;
                end
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q  <= M_BLINK;
        half_q  <= CNT_W'(DEF_HALF);
        burst_q <= 4'd1;
        cnt_q   <= '0;
        tcnt_q  <= '0;
        ph_q    <= PH_ACTIVE;
        led_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        half_q  <= half_d;
        burst_q <= burst_d;
        cnt_q   <= cnt_d;
        tcnt_q  <= tcnt_d;
        ph_q    <= ph_d;
        led_q   <= led_d;
        tick_q  <= tick_d;
      end
    end

    assign led[i]  = led_q;
    assign tick[i] = tick_q;
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// tb_led_blink_bank: self-checking bench for led_blink_bank (2 channels, half=4, gap=4).
// Expected led/tick come from a table of hand-derived vectors or from a closed-form
// waveform model, pushed to a scoreboard queue at each edge and popped mid-cycle.
module tb_led_blink_bank;

  localparam int NC  = 2;
  localparam int CW  = 16;
  localparam int DH  = 4;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [CW-1:0] cfg_half = '0;
  logic [3:0]    cfg_burst = '0;
  logic          sync = 1'b0;
  logic [NC-1:0] led;
  logic [NC-1:0] tick;

  led_blink_bank #(
    .N_CH(NC), .CNT_W(CW), .DEF_HALF(DH), .GAP_HALVES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_burst(cfg_burst), .sync(sync), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] led;
    logic [1:0] tick;
  } exp_t;

  typedef struct {
    logic       we;
    logic [3:0] ch;
    logic [1:0] mode;
    logic [CW-1:0] half;
    logic [3:0] burst;
    logic       sy;
    logic [1:0] exp_led;
    logic [1:0] exp_tick;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Closed-form model: per channel, edges elapsed since the last restart
  // plus the active config.
  int         mk[NC];
  logic [1:0] mm[NC];
  int         mh[NC];
  int         mb[NC];

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      mk[c] = 0; mm[c] = 2'd2; mh[c] = DH; mb[c] = 1;
    end
  endfunction

  function automatic void model_step(input logic we, input logic [3:0] ch, input logic [1:0] mode,
                                     input logic [CW-1:0] half, input logic [3:0] burst, input logic sy);
    for (int c = 0; c < NC; c++) begin
      if (we && ch == 4'(c)) begin
        mm[c] = mode;
        mh[c] = (half == 0) ? 1 : int'(half);
        mb[c] = int'(burst);
        mk[c] = 0;
      end else if (sy) begin
        mk[c] = 0;
      end else begin
        mk[c] = mk[c] + 1;
      end
    end
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    int m, p, h, lim;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      h = mh[c];
      case (mm[c])
        2'd1: e.led[c] = 1'b1;
        2'd2: begin
          e.led[c]  = ((mk[c] / h) % 2) == 1;
          e.tick[c] = (mk[c] > 0) && ((mk[c] % h) == 0);
        end
        2'd3: if (mb[c] != 0) begin
          lim = 2 * h * mb[c];
          p   = lim + GAP * h;
          m   = mk[c] % p;
          e.led[c]  = (m < lim) && (((m / h) % 2) == 1);
          e.tick[c] = ((m % h) == 0) && (m >= h) && (m <= lim);
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got led=%b expected an entry", name, led);
    end else begin
      e = sbq.pop_front();
      check($sformatf("%s_led[%0d]", name, cyc), led, e.led);
      check($sformatf("%s_tick[%0d]", name, cyc), tick, e.tick);
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at the next negedge.
  task automatic cycle(input logic we, input logic [3:0] ch, input logic [1:0] mode,
                       input logic [CW-1:0] half, input logic [3:0] burst, input logic sy,
                       input bit use_tab, input logic [1:0] tl, input logic [1:0] tt,
                       input string name);
    exp_t e;
    cfg_we = we; cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_burst = burst; sync = sy;
    @(posedge clk);
    cyc++;
    model_step(we, ch, mode, half, burst, sy);
    if (use_tab) e = '{led: tl, tick: tt};
    else         e = model_exp();
    sbq.push_back(e);
    @(negedge clk);
    cfg_we = 1'b0; sync = 1'b0;
    pop_check(name);
  endtask

  task automatic run(input int n, input string name);
    for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 2'd0, '0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00, name);
  endtask

  task automatic wr(input logic [3:0] ch, input logic [1:0] mode, input logic [CW-1:0] half,
                    input logic [3:0] burst, input logic sy, input string name);
    cycle(1'b1, ch, mode, half, burst, sy, 1'b0, 2'b00, 2'b00, name);
  endtask

  vec_t tab[13];
  int   first_tick;

  initial begin
    // Post-reset blink, then an ON write and an out-of-range write.
    for (int k = 0; k < 10; k++) tab[k] = '{1'b0, 4'd0, 2'd0, 16'd0, 4'd0, 1'b0, 2'b00, 2'b00};
    tab[3].exp_led = 2'b11; tab[3].exp_tick = 2'b11;
    tab[4].exp_led = 2'b11; tab[5].exp_led = 2'b11; tab[6].exp_led = 2'b11;
    tab[7].exp_led = 2'b00; tab[7].exp_tick = 2'b11;
    tab[10] = '{1'b1, 4'd0, 2'd1, 16'd0, 4'd0, 1'b0, 2'b01, 2'b00};
    tab[11] = '{1'b1, 4'd5, 2'd0, 16'd3, 4'd0, 1'b0, 2'b11, 2'b10};
    tab[12] = '{1'b0, 4'd0, 2'd0, 16'd0, 4'd0, 1'b0, 2'b11, 2'b00};

    model_reset();
    @(negedge clk);
    check("reset_led", led, 2'b00);
    check("reset_tick", tick, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 13; k++)
      cycle(tab[k].we, tab[k].ch, tab[k].mode, tab[k].half, tab[k].burst, tab[k].sy,
            1'b1, tab[k].exp_led, tab[k].exp_tick, "table");

    wr(4'd1, 2'd2, 16'd0, 4'd0, 1'b0, "half0_wr");
    run(6, "half0");

    wr(4'd0, 2'd3, 16'd2, 4'd3, 1'b0, "burst_wr");
    run(44, "burst");

    wr(4'd0, 2'd2, 16'd4, 4'd0, 1'b0, "phase_wr0");
    run(2, "phase_a");
    wr(4'd1, 2'd2, 16'd4, 4'd0, 1'b0, "phase_wr1");
    run(2, "phase_b");
    cycle(1'b0, 4'd0, 2'd0, '0, 4'd0, 1'b1, 1'b0, 2'b00, 2'b00, "sync");
    run(9, "post_sync");

    run(1, "mid_a");
    wr(4'd1, 2'd2, 16'd2, 4'd0, 1'b0, "midchange_wr");
    run(6, "midchange");

    wr(4'd0, 2'd1, 16'd0, 4'd0, 1'b1, "sync_we");
    run(6, "sync_we_run");

    wr(4'd1, 2'd3, 16'd3, 4'd0, 1'b0, "burst0_wr");
    run(5, "burst0");

    wr(4'd0, 2'd3, 16'd2, 4'd2, 1'b0, "pre_rst_wr0");
    wr(4'd1, 2'd2, 16'd1, 4'd0, 1'b0, "pre_rst_wr1");
    run(2, "pre_rst");

    // Reset asserted between edges must clear the outputs immediately.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", led, 2'b00);
    check("async_rst_tick", tick, 2'b00);
    @(negedge clk);
    check("rst_hold_led", led, 2'b00);
    check("rst_hold_tick", tick, 2'b00);
    rst = 1'b0;
    model_reset();

    first_tick = -1;
    for (int k = 1; k <= 10; k++) begin
      run(1, "post_rst");
      if (first_tick < 0 && tick == 2'b11) first_tick = k;
    end
    checks++;
    if (first_tick != DH) begin
      failures++;
      $display("FAIL post_rst_first_toggle: got edge %0d expected edge %0d", first_tick, DH);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
